// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_clock_pkg
//  Purpose  : Shared states, time-word field layout and output codes for the
//             alarm clock mode controller.
//  Revision : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    typedef enum logic [2:0] {
        ST_CLOCK        = 3'd0,
        ST_ADJ_TIME_HR  = 3'd1,
        ST_ADJ_TIME_MIN = 3'd2,
        ST_ADJ_ALM_HR   = 3'd3,
        ST_ADJ_ALM_MIN  = 3'd4,
        ST_ALARM        = 3'd5
    } state_t;

    localparam int SEC_LSB = 0;
    localparam int MIN_LSB = 8;
    localparam int HR_LSB  = 16;
    localparam int HR_W    = 6;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    localparam logic [1:0] EN_NONE = 2'b00;
    localparam logic [1:0] EN_MIN  = 2'b01;
    localparam logic [1:0] EN_HR   = 2'b10;

    function automatic logic clk_en_of(input state_t s);
        return (s == ST_CLOCK) || (s == ST_ALARM);
    endfunction

    function automatic logic [1:0] en_time_of(input state_t s);
        case (s)
            ST_ADJ_TIME_HR, ST_ADJ_ALM_HR:   return EN_HR;
            ST_ADJ_TIME_MIN, ST_ADJ_ALM_MIN: return EN_MIN;
            default:                         return EN_NONE;
        endcase
    endfunction

    // Adjust ring: TIME_HR -> TIME_MIN -> ALM_HR -> ALM_MIN -> TIME_HR
    function automatic state_t adj_next(input state_t s);
        case (s)
            ST_ADJ_TIME_HR:  return ST_ADJ_TIME_MIN;
            ST_ADJ_TIME_MIN: return ST_ADJ_ALM_HR;
            ST_ADJ_ALM_HR:   return ST_ADJ_ALM_MIN;
            default:         return ST_ADJ_TIME_HR;
        endcase
    endfunction

    function automatic state_t adj_prev(input state_t s);
        case (s)
            ST_ADJ_TIME_HR:  return ST_ADJ_ALM_MIN;
            ST_ADJ_TIME_MIN: return ST_ADJ_TIME_HR;
            ST_ADJ_ALM_HR:   return ST_ADJ_TIME_MIN;
            default:         return ST_ADJ_ALM_HR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_field_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_field_step
//  Purpose  : One-step increment/decrement of a two-digit BCD field that wraps
//             between 00 and MAX.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_field_step #(
    parameter int MAX = 59
) (
    input  logic [7:0] value,
    input  logic       dec,
    output logic [7:0] next_value
);

    localparam logic [3:0] MAX_TENS  = 4'(MAX / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX % 10);

    logic [3:0] w_tens;
    logic [3:0] w_units;

    assign w_tens  = value[7:4];
    assign w_units = value[3:0];

    always_comb begin
        next_value = value;
        if (dec) begin
            if (value == 8'h00)
                next_value = {MAX_TENS, MAX_UNITS};
            else if (w_units == 4'd0)
                next_value = {w_tens - 4'd1, 4'd9};
            else
                next_value = {w_tens, w_units - 4'd1};
        end else begin
            if (value == {MAX_TENS, MAX_UNITS})
                next_value = 8'h00;
            else if (w_units == 4'd9)
                next_value = {w_tens + 4'd1, 4'd0};
            else
                next_value = {w_tens, w_units + 4'd1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_clock_ctrl
//  Purpose  : Mode controller and alarm scheduler for the digital alarm clock.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_clock_ctrl #(
    parameter int ALARM_TIMEOUT = 60,
    parameter int TIME_W        = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_c,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic [TIME_W-1:0] time_count,
    output logic              clk_en,
    output logic              load,
    output logic [TIME_W-1:0] load_value,
    output logic [1:0]        en_time,
    output logic [TIME_W-1:0] alarm_value,
    output logic              alarm_armed,
    output logic              buzz,
    output logic [2:0]        mode
);

    import alarm_clock_pkg::*;

    localparam int CNT_W = $clog2(ALARM_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [13:0]      r_edit_hm;
    logic [13:0]      r_alarm_hm;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_match_q;

    logic w_c, w_l, w_r, w_u, w_d, w_any_btn, w_step;
    logic w_match, w_trigger, w_timeout;
    logic w_alm_sel, w_hr_sel;

    logic [13:0] w_src_hm;
    logic [13:0] w_stepped_hm;
    logic [7:0]  w_hr_next;
    logic [7:0]  w_min_next;
    logic [5:0]  w_hr_field;

    // Fixed priority c > l > r > u > d: only the winning pulse survives.
    assign w_c       = btn_c;
    assign w_l       = btn_l & ~btn_c;
    assign w_r       = btn_r & ~btn_c & ~btn_l;
    assign w_u       = btn_u & ~btn_c & ~btn_l & ~btn_r;
    assign w_d       = btn_d & ~btn_c & ~btn_l & ~btn_r & ~btn_u;
    assign w_any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;
    assign w_step    = w_u | w_d;

    // Raw match is tracked in every state so returning to CLOCK mid-match never re-fires.
    assign w_match   = alarm_armed
                     && (time_count[HR_LSB+HR_W-1:MIN_LSB] == r_alarm_hm)
                     && (time_count[MIN_LSB-1:SEC_LSB] == 8'h00);
    assign w_trigger = (r_state == ST_CLOCK) && w_match && !r_match_q;

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_timeout   = tick_1hz && (w_count_inc == CNT_W'(ALARM_TIMEOUT));

    assign w_alm_sel = (r_state == ST_ADJ_ALM_HR) || (r_state == ST_ADJ_ALM_MIN);
    assign w_hr_sel  = (r_state == ST_ADJ_TIME_HR) || (r_state == ST_ADJ_ALM_HR);
    assign w_src_hm  = w_alm_sel ? r_alarm_hm : r_edit_hm;

    bcd_field_step #(.MAX(HR_MAX)) u_hr_step (
        .value      ({2'b00, w_src_hm[13:8]}),
        .dec        (w_d),
        .next_value (w_hr_next)
    );

    bcd_field_step #(.MAX(MIN_MAX)) u_min_step (
        .value      (w_src_hm[7:0]),
        .dec        (w_d),
        .next_value (w_min_next)
    );

    // Hour tens never exceed 2; out-of-range upper bits collapse the field to 00.
    assign w_hr_field   = (w_hr_next[7:6] != 2'b00) ? 6'h00 : w_hr_next[5:0];
    assign w_stepped_hm = w_hr_sel ? {w_hr_field, w_src_hm[7:0]}
                                   : {w_src_hm[13:8], w_min_next};

    assign alarm_value = TIME_W'({r_alarm_hm, 8'h00});

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLOCK: begin
                if (w_trigger)
                    w_next_state = ST_ALARM;
                else if (w_c)
                    w_next_state = ST_ADJ_TIME_HR;
            end
            ST_ALARM: begin
                if (w_any_btn || w_timeout)
                    w_next_state = ST_CLOCK;
            end
            ST_ADJ_TIME_HR, ST_ADJ_TIME_MIN, ST_ADJ_ALM_HR, ST_ADJ_ALM_MIN: begin
                if (w_c)
                    w_next_state = ST_CLOCK;
                else if (w_l)
                    w_next_state = adj_prev(r_state);
                else if (w_r)
                    w_next_state = adj_next(r_state);
            end
            default: w_next_state = ST_CLOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLOCK;
            mode        <= ST_CLOCK;
            clk_en      <= 1'b0;
            en_time     <= EN_NONE;
            load        <= 1'b0;
            load_value  <= '0;
            r_edit_hm   <= '0;
            r_alarm_hm  <= '0;
            alarm_armed <= 1'b0;
            buzz        <= 1'b0;
            r_match_q   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state   <= w_next_state;
            mode      <= w_next_state;
            clk_en    <= clk_en_of(w_next_state);
            en_time   <= en_time_of(w_next_state);
            r_match_q <= w_match;
            load      <= 1'b0;

            case (r_state)
                ST_CLOCK: begin
                    if (w_trigger) begin
                        buzz    <= 1'b1;
                        r_count <= '0;
                    end else if (w_c) begin
                        r_edit_hm <= time_count[HR_LSB+HR_W-1:MIN_LSB];
                    end else if (w_u) begin
                        alarm_armed <= ~alarm_armed;
                    end
                end
                ST_ALARM: begin
                    if (w_any_btn || w_timeout)
                        buzz <= 1'b0;
                    if (tick_1hz)
                        r_count <= w_count_inc;
                end
                default: begin
                    if (!w_c && !w_l && !w_r && w_step) begin
                        if (w_alm_sel) begin
                            r_alarm_hm <= w_stepped_hm;
                        end else begin
                            r_edit_hm  <= w_stepped_hm;
                            load       <= 1'b1;
                            load_value <= TIME_W'({w_stepped_hm, 8'h00});
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_clock_ctrl
//  Purpose  : Scoreboard bench for alarm_clock_ctrl against a behavioural
//             model of the mode controller and alarm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_ctrl;

    import alarm_clock_pkg::*;

    localparam int TO = 3;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [21:0] time_count = '0;
    logic        clk_en, load, alarm_armed, buzz;
    logic [21:0] load_value, alarm_value;
    logic [1:0]  en_time;
    logic [2:0]  mode;

    alarm_clock_ctrl #(.ALARM_TIMEOUT(TO), .TIME_W(22)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .time_count(time_count), .clk_en(clk_en), .load(load), .load_value(load_value),
        .en_time(en_time), .alarm_value(alarm_value), .alarm_armed(alarm_armed),
        .buzz(buzz), .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  mode;
        logic        clk_en;
        logic        load;
        logic [21:0] load_value;
        logic [1:0]  en_time;
        logic [21:0] alarm_value;
        logic        alarm_armed;
        logic        buzz;
    } obs_t;

    obs_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Model state: -1 = clock, -2 = alarm, 0..3 = TIME_HR, TIME_MIN, ALM_HR, ALM_MIN
    int m_st = -1;
    int e_h, e_m, a_h, a_m, lv_h, lv_m, cnt;
    bit m_armed, m_buzz, m_prev, m_clk_en, m_load;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [21:0] tword(input int h, input int m, input int s);
        logic [7:0] hb;
        hb = bcd(h);
        return {hb[5:0], bcd(m), bcd(s)};
    endfunction

    function automatic logic [2:0] mode_of(input int st);
        case (st)
            -2:      return ST_ALARM;
            0:       return ST_ADJ_TIME_HR;
            1:       return ST_ADJ_TIME_MIN;
            2:       return ST_ADJ_ALM_HR;
            3:       return ST_ADJ_ALM_MIN;
            default: return ST_CLOCK;
        endcase
    endfunction

    function automatic logic [1:0] en_of(input int st);
        if (st == 0 || st == 2) return 2'b10;
        if (st == 1 || st == 3) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_step(input bit rst, input logic [4:0] b, input bit tk,
                              input int h, input int m, input int s);
        int press;
        int dir;
        bit raw, trig;
        if (rst) begin
            m_st = -1; e_h = 0; e_m = 0; a_h = 0; a_m = 0; lv_h = 0; lv_m = 0; cnt = 0;
            m_armed = 0; m_buzz = 0; m_prev = 0; m_clk_en = 0; m_load = 0;
            return;
        end
        raw    = m_armed && h == a_h && m == a_m && s == 0;
        trig   = (m_st == -1) && raw && !m_prev;
        m_prev = raw;
        m_load = 0;
        press  = b[4] ? 1 : b[3] ? 2 : b[2] ? 3 : b[1] ? 4 : b[0] ? 5 : 0;
        if (m_st == -1) begin
            if (trig) begin
                m_st = -2; m_buzz = 1; cnt = 0;
            end else if (press == 1) begin
                m_st = 0; e_h = h; e_m = m;
            end else if (press == 4) begin
                m_armed = !m_armed;
            end
        end else if (m_st == -2) begin
            if (press != 0) begin
                m_st = -1; m_buzz = 0;
            end else if (tk) begin
                cnt++;
                if (cnt == TO) begin
                    m_st = -1; m_buzz = 0;
                end
            end
        end else begin
            if (press == 1)      m_st = -1;
            else if (press == 2) m_st = (m_st + 3) % 4;
            else if (press == 3) m_st = (m_st + 1) % 4;
            else if (press >= 4) begin
                dir = (press == 4) ? 1 : -1;
                case (m_st)
                    0: e_h = (e_h + 24 + dir) % 24;
                    1: e_m = (e_m + 60 + dir) % 60;
                    2: a_h = (a_h + 24 + dir) % 24;
                    default: a_m = (a_m + 60 + dir) % 60;
                endcase
                if (m_st < 2) begin
                    m_load = 1; lv_h = e_h; lv_m = e_m;
                end
            end
        end
        m_clk_en = (m_st < 0);
    endtask

    task automatic cyc(input bit rst, input logic [4:0] b, input bit tk,
                       input int h, input int m, input int s);
        obs_t e;
        @(negedge clk);
        reset = rst;
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        tick_1hz   = tk;
        time_count = tword(h, m, s);
        model_step(rst, b, tk, h, m, s);
        e = '{mode: mode_of(m_st), clk_en: m_clk_en, load: m_load,
              load_value: tword(lv_h, lv_m, 0), en_time: en_of(m_st),
              alarm_value: tword(a_h, a_m, 0), alarm_armed: m_armed, buzz: m_buzz};
        exp_q.push_back(e);
    endtask

    // Press a button then release for one cycle, with a constant time input.
    task automatic tap(input logic [4:0] b, input int n, input int h, input int m, input int s);
        for (int i = 0; i < n; i++) begin
            cyc(0, b, 0, h, m, s);
            cyc(0, 5'b0, 0, h, m, s);
        end
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{mode: mode, clk_en: clk_en, load: load, load_value: load_value,
                      en_time: en_time, alarm_value: alarm_value,
                      alarm_armed: alarm_armed, buzz: buzz};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t got mode=%0d clk_en=%b load=%b lv=%h en=%b alm=%h armed=%b buzz=%b | want mode=%0d clk_en=%b load=%b lv=%h en=%b alm=%h armed=%b buzz=%b",
                             $time, a.mode, a.clk_en, a.load, a.load_value, a.en_time,
                             a.alarm_value, a.alarm_armed, a.buzz, e.mode, e.clk_en, e.load,
                             e.load_value, e.en_time, e.alarm_value, e.alarm_armed, e.buzz);
                end
            end
        end
    end

    initial begin : stimulus
        int h, m, s, r;
        cyc(1, 5'b0, 0, 0, 0, 0);
        cyc(1, 5'b0, 0, 0, 0, 0);
        cyc(0, 5'b0, 0, 12, 34, 56);
        cyc(0, 5'b0, 0, 12, 34, 56);

        // Enter time adjust, step hours up through the 23 -> 00 wrap
        tap(B_C, 1, 12, 34, 56);
        tap(B_U, 12, 12, 34, 56);
        // Minutes down from 34 through the 00 -> 59 wrap
        tap(B_R, 1, 12, 34, 56);
        tap(B_D, 35, 12, 34, 56);
        // Reverse then forward to alarm hours; set alarm to 07:30
        tap(B_L, 1, 12, 34, 56);
        tap(B_R, 2, 12, 34, 56);
        tap(B_U, 7, 12, 34, 56);
        tap(B_R, 1, 12, 34, 56);
        tap(B_U, 30, 12, 34, 56);
        tap(B_C, 1, 12, 34, 56);
        tap(B_U, 1, 7, 29, 59);

        // Trigger, acknowledge, no retrigger within the same second
        for (int i = 0; i < 3; i++) cyc(0, 5'b0, 0, 7, 29, 59);
        for (int i = 0; i < 3; i++) cyc(0, 5'b0, 0, 7, 30, 0);
        cyc(0, B_D, 0, 7, 30, 0);
        for (int i = 0; i < 5; i++) cyc(0, 5'b0, 0, 7, 30, 0);
        cyc(0, 5'b0, 0, 7, 30, 1);

        // Self-silence after TO ticks
        cyc(0, 5'b0, 0, 7, 29, 59);
        cyc(0, 5'b0, 0, 7, 30, 0);
        for (int i = 0; i < 16; i++) cyc(0, 5'b0, (i % 4) == 3, 7, 30, 0);
        cyc(0, 5'b0, 0, 7, 30, 1);

        // Simultaneous c and u in CLOCK: only c acts
        cyc(0, B_C | B_U, 0, 9, 15, 20);
        cyc(0, 5'b0, 0, 9, 15, 20);
        cyc(0, B_C | B_D | B_R, 0, 9, 15, 20);
        cyc(0, 5'b0, 0, 9, 15, 20);

        // Reset while ringing
        cyc(0, 5'b0, 0, 7, 29, 59);
        cyc(0, 5'b0, 0, 7, 30, 0);
        cyc(0, 5'b0, 0, 7, 30, 0);
        cyc(1, 5'b0, 0, 7, 30, 0);
        cyc(0, 5'b0, 0, 7, 30, 0);

        // Randomised single-button traffic around the alarm time
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                h = a_h; m = a_m; s = ($urandom_range(2, 0) == 2) ? 1 : 0;
            end else begin
                h = $urandom_range(23, 0); m = $urandom_range(59, 0); s = $urandom_range(59, 0);
            end
            r = $urandom_range(9, 0);
            cyc(($urandom_range(599, 0) == 0), (r < 5) ? 5'(1 << r) : 5'b0,
                ($urandom_range(3, 0) == 0), h, m, s);
        end
        cyc(0, 5'b0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
